i2c_slave: RTL and testbench

- I2C responder (target) for the team's i2c_master: 7-bit address, 8-bit data, read and write.
- Oversamples SCL/SDA on a local system clock and detects START/STOP.
- Matches one fixed address, ACKs it, and shifts data in or out over an open-drain SDA.
- Presents received bytes and read requests to a local register/user interface.

---
 rtl/i2c_slave.sv | 188 ++++++++++++++++++
 tb/tb_i2c_slave.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// i2c_slave: 7-bit address I2C target with open-drain SDA, write capture and read request interface.
// Optional 3-sample majority glitch filter on SCL/SDA when I2C_SLAVE_GLITCH_FILTER_EN is defined.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       input_clk,
  input  logic       i_rst_n,
  input  logic       i_scl,
  inout  wire        io_sda,
  input  logic [7:0] i_rd_data,
  output logic       o_rd_req,
  output logic [7:0] o_wr_data,
  output logic       o_wr_valid,
  output logic       o_busy,
  output logic [2:0] o_status
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP} state_e;
  state_e state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_s, sda_s, scl_p_q, sda_p_q;
  logic scl_rise, scl_fall, start, stop;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, wr_data_q, wr_data_d;
  logic [2:0] status_q, status_d;
  logic oe_q, oe_d, rw_q, rw_d, pend_q, pend_d, busy_q, busy_d;
  logic wr_valid_q, wr_valid_d, rd_req_q, rd_req_d;
  assign io_sda = oe_q ? 1'b0 : 1'bz;
  always_ff @(posedge input_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i_scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], io_sda};
      scl_p_q    <= scl_s;
      sda_p_q    <= sda_s;
    end
  end
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_h_q, sda_h_q;
  logic scl_f_q, sda_f_q, scl_y, sda_y;
  assign scl_y = scl_sync_q[SYNC_STAGES-1];
  assign sda_y = sda_sync_q[SYNC_STAGES-1];
  always_ff @(posedge input_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_h_q <= '1;
      sda_h_q <= '1;
      scl_f_q <= 1'b1;
      sda_f_q <= 1'b1;
    end else begin
      scl_h_q <= {scl_h_q[0], scl_y};
      sda_h_q <= {sda_h_q[0], sda_y};
      scl_f_q <= (scl_y & scl_h_q[0]) | (scl_y & scl_h_q[1]) | (scl_h_q[0] & scl_h_q[1]);
      sda_f_q <= (sda_y & sda_h_q[0]) | (sda_y & sda_h_q[1]) | (sda_h_q[0] & sda_h_q[1]);
    end
  end
  assign scl_s = scl_f_q;
  assign sda_s = sda_f_q;
`else
  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];
`endif
  assign scl_rise = scl_s & ~scl_p_q;
  assign scl_fall = ~scl_s & scl_p_q;
  assign start    = scl_s & scl_p_q & sda_p_q & ~sda_s;
  assign stop     = scl_s & scl_p_q & ~sda_p_q & sda_s;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    oe_d       = oe_q;
    rw_d       = rw_q;
    pend_d     = pend_q;
    busy_d     = busy_q;
    status_d   = status_q;
    wr_data_d  = wr_data_q;
    wr_valid_d = 1'b0;
    rd_req_d   = 1'b0;
    if (start) begin
      state_d  = ADDR;
      cnt_d    = '0;
      status_d = '0;
      oe_d     = 1'b0;
      pend_d   = 1'b0;
    end else if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          sh_d  = {sh_q[6:0], sda_s};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d   = '0;
            state_d = (sh_q[6:0] == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
            if (sh_q[6:0] == SLAVE_ADDR) begin
              status_d[0] = 1'b1;
              busy_d      = 1'b1;
              rw_d        = sda_s;
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          oe_d     = ~oe_q;
          rd_req_d = oe_q & rw_q;
          state_d  = oe_q ? (rw_q ? RD_DATA : WR_DATA) : ADDR_ACK;
          cnt_d    = '0;
        end
        WR_DATA: if (scl_rise) begin
          sh_d  = {sh_q[6:0], sda_s};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            wr_data_d   = {sh_q[6:0], sda_s};
            wr_valid_d  = 1'b1;
            status_d[2] = status_q[2] | pend_q;
            pend_d      = 1'b1;
            cnt_d       = '0;
            state_d     = WR_ACK;
          end
        end
        WR_ACK: if (scl_fall) begin
          oe_d    = ~oe_q;
          pend_d  = pend_q & ~oe_q;
          state_d = oe_q ? WR_DATA : WR_ACK;
        end
        // the requested byte is loaded while o_rd_req is high, so the user has one cycle to present it
        RD_DATA: if (rd_req_q) begin
          sh_d = {i_rd_data[6:0], 1'b1};
          oe_d = ~i_rd_data[7];
        end else if (scl_rise) begin
          cnt_d = cnt_q + 4'd1;
        end else if (scl_fall) begin
          sh_d    = (cnt_q == 4'd8) ? sh_q : {sh_q[6:0], 1'b1};
          oe_d    = (cnt_q == 4'd8) ? 1'b0 : ~sh_q[7];
          state_d = (cnt_q == 4'd8) ? RD_ACK : RD_DATA;
          cnt_d   = (cnt_q == 4'd8) ? 4'd0 : cnt_q;
        end
        RD_ACK: if (scl_rise) begin
          status_d[1] = status_q[1] | sda_s;
          state_d     = sda_s ? WAIT_STOP : RD_ACK;
          cnt_d       = sda_s ? 4'd0 : 4'd1;
        end else if (scl_fall && cnt_q == 4'd1) begin
          rd_req_d = 1'b1;
          cnt_d    = '0;
          state_d  = RD_DATA;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge input_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      oe_q       <= 1'b0;
      rw_q       <= 1'b0;
      pend_q     <= 1'b0;
      busy_q     <= 1'b0;
      status_q   <= '0;
      wr_data_q  <= '0;
      wr_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      oe_q       <= oe_d;
      rw_q       <= rw_d;
      pend_q     <= pend_d;
      busy_q     <= busy_d;
      status_q   <= status_d;
      wr_data_q  <= wr_data_d;
      wr_valid_q <= wr_valid_d;
      rd_req_q   <= rd_req_d;
    end
  end
  assign o_rd_req   = rd_req_q;
  assign o_wr_data  = wr_data_q;
  assign o_wr_valid = wr_valid_q;
  assign o_busy     = busy_q;
  assign o_status   = status_q;
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-level I2C master driving i2c_slave, checked against transaction-level expectations.
module tb_i2c_slave;
  logic clk = 1'b0, rst_n = 1'b0, scl = 1'b1, m_low = 1'b0;
  logic [7:0] rd_data = 8'h00;
  wire sda;
  logic rd_req, wr_valid, busy;
  logic [7:0] wr_data;
  logic [2:0] status;
  int n_chk = 0, n_pass = 0, wv_cnt = 0, rr_cnt = 0;
  bit slave_low = 1'b0;
  logic [7:0] wr_q[$];
  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);
  always #5 clk = ~clk;
  i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .input_clk(clk), .i_rst_n(rst_n), .i_scl(scl), .io_sda(sda), .i_rd_data(rd_data),
    .o_rd_req(rd_req), .o_wr_data(wr_data), .o_wr_valid(wr_valid), .o_busy(busy), .o_status(status));
  always @(negedge clk) begin
    if (wr_valid) begin
      wv_cnt++;
      wr_q.push_back(wr_data);
    end
    if (rd_req) rr_cnt++;
    if (sda === 1'b0 && !m_low) slave_low = 1'b1;
  end
  task automatic wt(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  task automatic clk_bit(input bit b, output bit r);
    wt(4); m_low = !b;
    wt(4); scl = 1'b1;
    wt(4); r = sda;
    wt(4); scl = 1'b0;
  endtask
  task automatic start_c();
    if (!scl) begin
      wt(4); m_low = 1'b0;
      wt(8); scl = 1'b1;
      wt(8);
    end
    m_low = 1'b1;
    wt(8); scl = 1'b0;
  endtask
  task automatic stop_c();
    wt(4); m_low = 1'b1;
    wt(4); scl = 1'b1;
    wt(8); m_low = 1'b0;
    wt(8);
  endtask
  task automatic wbyte(input logic [7:0] b, output bit nack);
    bit d;
    for (int i = 0; i < 8; i++) clk_bit(b[7-i], d);
    clk_bit(1'b1, nack);
  endtask
  task automatic rbyte(output logic [7:0] b, input bit mnack, input logic [7:0] nxt);
    bit d;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, d);
      b[7-i] = d;
      if (i == 0) rd_data = nxt;
    end
    clk_bit(mnack, d);
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    wt(3);
    n_chk++; if ({busy, status, wr_valid, rd_req} !== 6'b0) $display("FAIL reset_outs act=%b exp=0", {busy, status, wr_valid, rd_req}); else n_pass++;
    n_chk++; if (wr_data !== 8'h00) $display("FAIL reset_wr_data act=%h exp=00", wr_data); else n_pass++;
    n_chk++; if (sda !== 1'b1) $display("FAIL reset_sda act=%b exp=1", sda); else n_pass++;
    rst_n = 1'b1;
    wt(5);
  endtask
  task automatic test_write_one();
    bit nk;
    wv_cnt = 0; wr_q.delete();
    start_c();
    wbyte(8'hA0, nk);
    n_chk++; if (nk !== 1'b0) $display("FAIL wr_addr_ack act=%b exp=0", nk); else n_pass++;
    n_chk++; if (busy !== 1'b1) $display("FAIL wr_busy act=%b exp=1", busy); else n_pass++;
    wbyte(8'h3C, nk);
    n_chk++; if (nk !== 1'b0) $display("FAIL wr_data_ack act=%b exp=0", nk); else n_pass++;
    n_chk++; if (wv_cnt !== 1) $display("FAIL wr_valid_cnt act=%0d exp=1", wv_cnt); else n_pass++;
    n_chk++; if (wr_data !== 8'h3C) $display("FAIL wr_data act=%h exp=3c", wr_data); else n_pass++;
    n_chk++; if (status !== 3'b001) $display("FAIL wr_status act=%b exp=001", status); else n_pass++;
    stop_c();
    n_chk++; if (busy !== 1'b0) $display("FAIL wr_busy_stop act=%b exp=0", busy); else n_pass++;
  endtask
  task automatic test_addr_mismatch();
    bit nk1, nk2;
    wv_cnt = 0; slave_low = 1'b0;
    start_c();
    wbyte(8'hA2, nk1);
    wbyte(8'h11, nk2);
    n_chk++; if ({nk1, nk2} !== 2'b11) $display("FAIL miss_nack act=%b exp=11", {nk1, nk2}); else n_pass++;
    n_chk++; if (slave_low !== 1'b0) $display("FAIL miss_sda_low act=%b exp=0", slave_low); else n_pass++;
    n_chk++; if (wv_cnt !== 0) $display("FAIL miss_wr_valid act=%0d exp=0", wv_cnt); else n_pass++;
    n_chk++; if (status !== 3'b000) $display("FAIL miss_status act=%b exp=000", status); else n_pass++;
    stop_c();
    n_chk++; if (busy !== 1'b0) $display("FAIL miss_busy act=%b exp=0", busy); else n_pass++;
  endtask
  task automatic test_read_nack();
    bit nk;
    logic [7:0] got;
    rr_cnt = 0; rd_data = 8'h5A;
    start_c();
    wbyte(8'hA1, nk);
    n_chk++; if (nk !== 1'b0) $display("FAIL rd_addr_ack act=%b exp=0", nk); else n_pass++;
    rbyte(got, 1'b1, 8'h00);
    n_chk++; if (got !== 8'h5A) $display("FAIL rd_byte act=%h exp=5a", got); else n_pass++;
    n_chk++; if (rr_cnt !== 1) $display("FAIL rd_req_cnt act=%0d exp=1", rr_cnt); else n_pass++;
    n_chk++; if (status !== 3'b011) $display("FAIL rd_status act=%b exp=011", status); else n_pass++;
    stop_c();
  endtask
  task automatic test_burst_read();
    bit nk;
    logic [7:0] b0, b1;
    rr_cnt = 0; rd_data = 8'h81;
    start_c();
    wbyte(8'hA1, nk);
    rbyte(b0, 1'b0, 8'h7E);
    rbyte(b1, 1'b1, 8'h00);
    n_chk++; if ({b0, b1} !== 16'h817E) $display("FAIL burst_bytes act=%h exp=817e", {b0, b1}); else n_pass++;
    n_chk++; if (rr_cnt !== 2) $display("FAIL burst_req_cnt act=%0d exp=2", rr_cnt); else n_pass++;
    stop_c();
  endtask
  task automatic test_repeated_start();
    bit nk;
    logic [7:0] got;
    rd_data = 8'hC3;
    start_c();
    wbyte(8'hA0, nk);
    n_chk++; if (status !== 3'b001) $display("FAIL rs_status_pre act=%b exp=001", status); else n_pass++;
    start_c();
    n_chk++; if (status !== 3'b000) $display("FAIL rs_status_clr act=%b exp=000", status); else n_pass++;
    wbyte(8'hA1, nk);
    n_chk++; if ({nk, status} !== 4'b0001) $display("FAIL rs_addr act=%b exp=0001", {nk, status}); else n_pass++;
    rbyte(got, 1'b1, 8'h00);
    n_chk++; if (got !== 8'hC3) $display("FAIL rs_rd_byte act=%h exp=c3", got); else n_pass++;
    stop_c();
  endtask
  task automatic test_reset_mid_read();
    bit nk;
    rd_data = 8'h5A;
    start_c();
    wbyte(8'hA1, nk);
    wt(8);
    n_chk++; if (sda !== 1'b0) $display("FAIL mid_sda_driven act=%b exp=0", sda); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (sda !== 1'b1) $display("FAIL mid_sda_release act=%b exp=1", sda); else n_pass++;
    n_chk++; if ({busy, status, rd_req, wr_valid} !== 6'b0) $display("FAIL mid_outs act=%b exp=0", {busy, status, rd_req, wr_valid}); else n_pass++;
    wt(2); rst_n = 1'b1;
    wt(4);
    stop_c();
    wv_cnt = 0;
    start_c();
    wbyte(8'hA0, nk);
    wbyte(8'h96, nk);
    n_chk++; if ({wv_cnt == 1, wr_data} !== {1'b1, 8'h96}) $display("FAIL mid_after act=%h exp=96", wr_data); else n_pass++;
    stop_c();
  endtask
  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [6:0] a;
      logic [7:0] d[3];
      logic [7:0] got;
      bit rw, hit, nk;
      int n;
      a = (($urandom & 1) != 0) ? 7'h50 : 7'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0 && a == 7'h50) a = 7'h51;
      rw = 1'($urandom);
      hit = (a == 7'h50);
      n = $urandom_range(1, 3);
      for (int k = 0; k < 3; k++) d[k] = 8'($urandom);
      wv_cnt = 0; rr_cnt = 0; wr_q.delete();
      rd_data = d[0];
      start_c();
      wbyte({a, rw}, nk);
      n_chk++; if (nk !== !hit) $display("FAIL rnd_addr_ack it=%0d act=%b exp=%b", it, nk, !hit); else n_pass++;
      for (int k = 0; k < n; k++) begin
        if (!rw) begin
          wbyte(d[k], nk);
          n_chk++; if (nk !== !hit) $display("FAIL rnd_wr_ack it=%0d act=%b exp=%b", it, nk, !hit); else n_pass++;
        end else begin
          rbyte(got, k == n - 1, d[(k + 1) % 3]);
          n_chk++; if (got !== (hit ? d[k] : 8'hFF)) $display("FAIL rnd_rd_byte it=%0d act=%h exp=%h", it, got, hit ? d[k] : 8'hFF); else n_pass++;
        end
      end
      n_chk++; if (wv_cnt !== ((hit && !rw) ? n : 0)) $display("FAIL rnd_wv_cnt it=%0d act=%0d exp=%0d", it, wv_cnt, (hit && !rw) ? n : 0); else n_pass++;
      n_chk++; if (rr_cnt !== ((hit && rw) ? n : 0)) $display("FAIL rnd_rr_cnt it=%0d act=%0d exp=%0d", it, rr_cnt, (hit && rw) ? n : 0); else n_pass++;
      n_chk++; if (status !== {1'b0, hit && rw, hit}) $display("FAIL rnd_status it=%0d act=%b exp=%b", it, status, {1'b0, hit && rw, hit}); else n_pass++;
      if (hit && !rw)
        for (int k = 0; k < n; k++) begin
          n_chk++; if (wr_q.size() <= k || wr_q[k] !== d[k]) $display("FAIL rnd_wr_byte it=%0d k=%0d exp=%h", it, k, d[k]); else n_pass++;
        end
      stop_c();
      n_chk++; if (busy !== 1'b0) $display("FAIL rnd_busy it=%0d act=%b exp=0", it, busy); else n_pass++;
    end
  endtask
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  task automatic test_glitch();
    bit nk;
    wt(8);
    m_low = 1'b1;
    wt(1);
    m_low = 1'b0;
    wt(10);
    scl = 1'b0;
    wbyte(8'hA0, nk);
    n_chk++; if (nk !== 1'b1) $display("FAIL glitch_start act=%b exp=1", nk); else n_pass++;
    stop_c();
  endtask
`endif
  initial begin
    test_reset();
    test_write_one();
    test_addr_mismatch();
    test_read_nack();
    test_burst_read();
    test_repeated_start();
    test_reset_mid_read();
    test_random();
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
